alu_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single registered 8-bit ALU between `NUM_REQ` requesters. Each requester presents operands and an opcode with a valid/ready handshake. The arbiter grants one request at a time, drives the ALU's `a`/`b`/`alu_op` inputs, and waits out the ALU's one-cycle register latency. It then returns the captured result, tagged with the requester index, on a single valid/ready response port. It sits between the instruction/requester logic and the ALU instance, sharing that instance's clock and reset.

---
 rtl/alu_arbiter_if.sv | 35 +++
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_arbiter.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, ALU and response buses of the ALU arbiter
interface alu_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) ();
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_a;
  logic [NUM_REQ*8-1:0] req_b;
  logic [NUM_REQ*4-1:0] req_op;
  logic [7:0]           alu_a;
  logic [7:0]           alu_b;
  logic [3:0]           alu_opsel;
  logic [7:0]           alu_out;
  logic                 alu_carry;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [ID_W-1:0]      rsp_id;
  logic [7:0]           rsp_data;
  logic                 rsp_carry;
  logic                 rsp_err;
  logic                 busy;

  modport slave (
    input  req_valid, req_a, req_b, req_op, alu_out, alu_carry, rsp_ready,
    output req_ready, alu_a, alu_b, alu_opsel, rsp_valid, rsp_id, rsp_data,
           rsp_carry, rsp_err, busy
  );

  modport master (
    output req_valid, req_a, req_b, req_op, alu_out, alu_carry, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_opsel, rsp_valid, rsp_id, rsp_data,
           rsp_carry, rsp_err, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter/sequencer sharing one registered 8-bit ALU
// Optional macro ALU_ARB_DIVZERO_EN traps divide-by-zero without issuing it to the ALU.
module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic          clock,
  input logic          reset,
  alu_arbiter_if.slave arb
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] last_grant_q;
  logic [7:0]      alu_a_q, alu_b_q;
  logic [3:0]      alu_opsel_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [7:0]      rsp_data_q;
  logic            rsp_carry_q;

  logic            pick_valid;
  logic [ID_W-1:0] pick_idx;
  logic [7:0]      pick_a, pick_b;
  logic [3:0]      pick_op;
  logic            div_zero;
  logic            grant;
  logic            capture;

  // Search upward from last_grant+1; iterating from the far end lets the nearest hit win.
  always_comb begin
    int idx;
    idx        = 0;
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant_q) + k) % NUM_REQ;
      if (arb.req_valid[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = ID_W'(idx);
      end
    end
  end

  assign pick_a  = arb.req_a[{pick_idx, 3'b000} +: 8];
  assign pick_b  = arb.req_b[{pick_idx, 3'b000} +: 8];
  assign pick_op = arb.req_op[{pick_idx, 2'b00} +: 4];

`ifdef ALU_ARB_DIVZERO_EN
  assign div_zero = (pick_op == 4'b0011) && (pick_b == 8'h00);
`else
  assign div_zero = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant   = 1'b1;
          state_d = div_zero ? RESP : ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        capture = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (arb.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    arb.req_ready = '0;
    if (grant) begin
      arb.req_ready[pick_idx] = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      alu_a_q      <= 8'h00;
      alu_b_q      <= 8'h00;
      alu_opsel_q  <= 4'h0;
      rsp_id_q     <= '0;
      rsp_data_q   <= 8'h00;
      rsp_carry_q  <= 1'b0;
    end else begin
      if (grant) begin
        last_grant_q <= pick_idx;
        rsp_id_q     <= pick_idx;
        if (div_zero) begin
          rsp_data_q  <= 8'hFF;
          rsp_carry_q <= 1'b0;
        end else begin
          alu_a_q     <= pick_a;
          alu_b_q     <= pick_b;
          alu_opsel_q <= pick_op;
        end
      end
      if (capture) begin
        rsp_data_q  <= arb.alu_out;
        rsp_carry_q <= arb.alu_carry;
      end
    end
  end

`ifdef ALU_ARB_DIVZERO_EN
  logic rsp_err_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_err_q <= 1'b0;
    end else if (grant && div_zero) begin
      rsp_err_q <= 1'b1;
    end else if (capture) begin
      rsp_err_q <= 1'b0;
    end
  end

  assign arb.rsp_err = rsp_err_q;
`else
  assign arb.rsp_err = 1'b0;
`endif

  assign arb.alu_a     = alu_a_q;
  assign arb.alu_b     = alu_b_q;
  assign arb.alu_opsel = alu_opsel_q;
  assign arb.rsp_valid = (state_q == RESP);
  assign arb.rsp_id    = rsp_id_q;
  assign arb.rsp_data  = rsp_data_q;
  assign arb.rsp_carry = rsp_carry_q;
  assign arb.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a registered ALU model
module tb_alu_arbiter;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  alu_arbiter_if #(.NUM_REQ(N), .ID_W(IW)) arb ();
  alu_arbiter #(.NUM_REQ(N), .ID_W(IW)) dut (.clock(clock), .reset(reset), .arb(arb));

  int n_checks = 0;
  int n_fail   = 0;
  int ptr;
  logic [7:0] a_m [N];
  logic [7:0] b_m [N];
  logic [3:0] op_m [N];

  // ALU: 0 add, 1 sub (carry = borrow), 2 mul (carry = high byte nonzero), 3 div, others 0
  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    logic [15:0] p;
    case (op)
      4'd0: return {1'b0, a} + {1'b0, b};
      4'd1: return {1'b0, a} - {1'b0, b};
      4'd2: begin
        p = 16'(a) * 16'(b);
        return {|p[15:8], p[7:0]};
      end
      4'd3: return (b == 8'h00) ? 9'h1FF : {1'b0, a / b};
      default: return 9'h000;
    endcase
  endfunction

  // {err, carry, data} the arbiter must report for a request
  function automatic logic [9:0] exp_rsp(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
`ifdef ALU_ARB_DIVZERO_EN
    if (op == 4'd3 && b == 8'h00) return {1'b1, 1'b0, 8'hFF};
`endif
    return {1'b0, alu_ref(a, b, op)};
  endfunction

  function automatic int exp_lat(input logic [7:0] b, input logic [3:0] op);
`ifdef ALU_ARB_DIVZERO_EN
    if (op == 4'd3 && b == 8'h00) return 1;
`endif
    return 3;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      arb.alu_out   <= 8'h00;
      arb.alu_carry <= 1'b0;
    end else begin
      {arb.alu_carry, arb.alu_out} <= alu_ref(arb.alu_a, arb.alu_b, arb.alu_opsel);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      arb.req_a[i*8 +: 8]  = a_m[i];
      arb.req_b[i*8 +: 8]  = b_m[i];
      arb.req_op[i*4 +: 4] = op_m[i];
    end
  endtask

  task automatic rand_ops(input bit no_dz);
    for (int i = 0; i < N; i++) begin
      a_m[i]  = 8'($urandom);
      b_m[i]  = 8'($urandom);
      op_m[i] = 4'($urandom_range(0, 15));
      if (no_dz && op_m[i] == 4'd3 && b_m[i] == 8'h00) b_m[i] = 8'h01;
    end
    drive_ops();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if (arb.req_ready !== 4'b0 || arb.busy !== 1'b0 || arb.rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ready=%b busy=%b valid=%b expected 0000/0/0", arb.req_ready, arb.busy, arb.rsp_valid);
    end
    n_checks++;
    if ({arb.alu_a, arb.alu_b, arb.alu_opsel} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_alu: got a=%h b=%h op=%h expected 0", arb.alu_a, arb.alu_b, arb.alu_opsel);
    end
    n_checks++;
    if ({arb.rsp_id, arb.rsp_data, arb.rsp_carry, arb.rsp_err} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_rsp: got id=%0d data=%h c=%b e=%b expected 0", arb.rsp_id, arb.rsp_data, arb.rsp_carry, arb.rsp_err);
    end
    reset = 1'b0;
    ptr   = N - 1;
    step();
  endtask

  task automatic test_single_add();
    int cnt;
    a_m[0] = 8'hF0; b_m[0] = 8'h20; op_m[0] = 4'd0;
    drive_ops();
    arb.req_valid = 4'b0001;
    #1;
    n_checks++;
    if (arb.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL add_grant: got %b expected 0001", arb.req_ready);
    end
    step();
    arb.req_valid = 4'b0000;
    n_checks++;
    if (arb.alu_a !== 8'hF0 || arb.alu_b !== 8'h20 || arb.alu_opsel !== 4'd0 || arb.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL add_issue: got a=%h b=%h op=%h busy=%b expected f0/20/0/1", arb.alu_a, arb.alu_b, arb.alu_opsel, arb.busy);
    end
    cnt = 1;
    while (!arb.rsp_valid && cnt < 12) begin step(); cnt++; end
    n_checks++;
    if (cnt !== 3) begin n_fail++; $display("FAIL add_latency: got %0d expected 3", cnt); end
    n_checks++;
    if (arb.rsp_id !== 2'd0 || arb.rsp_data !== 8'h10 || arb.rsp_carry !== 1'b1 || arb.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL add_rsp: got id=%0d data=%h c=%b e=%b expected 0/10/1/0", arb.rsp_id, arb.rsp_data, arb.rsp_carry, arb.rsp_err);
    end
    arb.rsp_ready = 1'b1;
    step();
    arb.rsp_ready = 1'b0;
    n_checks++;
    if (arb.busy !== 1'b0 || arb.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL add_done: got busy=%b valid=%b expected 0/0", arb.busy, arb.rsp_valid);
    end
    ptr = 0;
  endtask

  task automatic test_round_robin();
    int exp_id;
    logic [9:0] e;
    logic [N-1:0] expv;
    reset = 1'b1;
    step();
    reset = 1'b0;
    ptr   = N - 1;
    rand_ops(1'b1);
    arb.req_valid = 4'b1111;
    arb.rsp_ready = 1'b1;
    #1;
    for (int g = 0; g < 5; g++) begin
      exp_id = (ptr + 1) % N;
      expv = '0; expv[exp_id] = 1'b1;
      n_checks++;
      if (arb.req_ready !== expv) begin
        n_fail++; $display("FAIL rr_grant%0d: got %b expected %b", g, arb.req_ready, expv);
      end
      e = exp_rsp(a_m[exp_id], b_m[exp_id], op_m[exp_id]);
      step();
      rand_ops(1'b1);
      step();
      step();
      n_checks++;
      if (arb.rsp_valid !== 1'b1 || arb.rsp_id !== IW'(exp_id) || arb.rsp_data !== e[7:0] || arb.rsp_carry !== e[8]) begin
        n_fail++;
        $display("FAIL rr_rsp%0d: got v=%b id=%0d data=%h c=%b expected 1/%0d/%h/%b",
                 g, arb.rsp_valid, arb.rsp_id, arb.rsp_data, arb.rsp_carry, exp_id, e[7:0], e[8]);
      end
      step();
      ptr = exp_id;
    end
    arb.req_valid = 4'b0000;
    arb.rsp_ready = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    int cnt;
    a_m[3] = 8'd5; b_m[3] = 8'd3; op_m[3] = 4'd1;
    drive_ops();
    arb.req_valid = 4'b1000;
    #1;
    n_checks++;
    if (arb.req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_grant: got %b expected 1000", arb.req_ready); end
    step();
    arb.req_valid = 4'b0000;
    cnt = 1;
    while (!arb.rsp_valid && cnt < 12) begin step(); cnt++; end
    n_checks++;
    if (cnt !== 3) begin n_fail++; $display("FAIL bp_latency: got %0d expected 3", cnt); end
    arb.req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++;
      if (arb.rsp_valid !== 1'b1 || arb.rsp_data !== 8'd2 || arb.rsp_id !== 2'd3 || arb.busy !== 1'b1 || arb.req_ready !== 4'b0) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got v=%b data=%h id=%0d busy=%b ready=%b expected 1/02/3/1/0000",
                 i, arb.rsp_valid, arb.rsp_data, arb.rsp_id, arb.busy, arb.req_ready);
      end
      step();
    end
    arb.rsp_ready = 1'b1;
    step();
    arb.rsp_ready = 1'b0;
    n_checks++;
    if (arb.busy !== 1'b0 || arb.req_ready !== 4'b0001) begin
      n_fail++; $display("FAIL bp_release: got busy=%b ready=%b expected 0/0001", arb.busy, arb.req_ready);
    end
    arb.req_valid = 4'b0000;
    ptr = 3;
    step();
  endtask

  task automatic test_illegal_op();
    int cnt;
    a_m[1] = 8'($urandom); b_m[1] = 8'($urandom); op_m[1] = 4'b1010;
    drive_ops();
    arb.req_valid = 4'b0010;
    #1;
    n_checks++;
    if (arb.req_ready !== 4'b0010) begin n_fail++; $display("FAIL ill_grant: got %b expected 0010", arb.req_ready); end
    step();
    arb.req_valid = 4'b0000;
    cnt = 1;
    while (!arb.rsp_valid && cnt < 12) begin step(); cnt++; end
    n_checks++;
    if (cnt !== 3 || arb.rsp_id !== 2'd1 || arb.rsp_data !== 8'h00 || arb.rsp_carry !== 1'b0 || arb.rsp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ill_rsp: got lat=%0d id=%0d data=%h c=%b e=%b expected 3/1/00/0/0",
               cnt, arb.rsp_id, arb.rsp_data, arb.rsp_carry, arb.rsp_err);
    end
    arb.rsp_ready = 1'b1;
    step();
    arb.rsp_ready = 1'b0;
    ptr = 1;
  endtask

  task automatic test_div_zero();
    int cnt;
    logic [7:0] prev_a, prev_b;
    prev_a = a_m[1];
    prev_b = b_m[1];
    a_m[2] = 8'd9; b_m[2] = 8'd0; op_m[2] = 4'd3;
    drive_ops();
    arb.req_valid = 4'b0100;
    #1;
    n_checks++;
    if (arb.req_ready !== 4'b0100) begin n_fail++; $display("FAIL dz_grant: got %b expected 0100", arb.req_ready); end
    step();
    arb.req_valid = 4'b0000;
    cnt = 1;
    while (!arb.rsp_valid && cnt < 12) begin step(); cnt++; end
`ifdef ALU_ARB_DIVZERO_EN
    n_checks++;
    if (cnt !== 1 || arb.rsp_data !== 8'hFF || arb.rsp_carry !== 1'b0 || arb.rsp_err !== 1'b1 || arb.rsp_id !== 2'd2) begin
      n_fail++;
      $display("FAIL dz_rsp: got lat=%0d data=%h c=%b e=%b id=%0d expected 1/ff/0/1/2",
               cnt, arb.rsp_data, arb.rsp_carry, arb.rsp_err, arb.rsp_id);
    end
    n_checks++;
    if (arb.alu_opsel !== 4'b1010 || arb.alu_a !== prev_a || arb.alu_b !== prev_b) begin
      n_fail++;
      $display("FAIL dz_alu_held: got op=%h a=%h b=%h expected a/%h/%h", arb.alu_opsel, arb.alu_a, arb.alu_b, prev_a, prev_b);
    end
`else
    n_checks++;
    if (cnt !== 3 || arb.rsp_data !== 8'hFF || arb.rsp_carry !== 1'b1 || arb.rsp_err !== 1'b0 || arb.rsp_id !== 2'd2) begin
      n_fail++;
      $display("FAIL dz_rsp: got lat=%0d data=%h c=%b e=%b id=%0d expected 3/ff/1/0/2",
               cnt, arb.rsp_data, arb.rsp_carry, arb.rsp_err, arb.rsp_id);
    end
    n_checks++;
    if (arb.alu_opsel !== 4'd3 || arb.alu_a !== 8'd9 || arb.alu_b !== 8'd0) begin
      n_fail++; $display("FAIL dz_alu_issued: got op=%h a=%h b=%h expected 3/09/00", arb.alu_opsel, arb.alu_a, arb.alu_b);
    end
`endif
    arb.rsp_ready = 1'b1;
    step();
    arb.rsp_ready = 1'b0;
    ptr = 2;
  endtask

  task automatic test_reset_mid();
    int bad;
    a_m[1] = 8'd16; b_m[1] = 8'd16; op_m[1] = 4'd2;
    drive_ops();
    arb.req_valid = 4'b0010;
    #1;
    n_checks++;
    if (arb.req_ready !== 4'b0010) begin n_fail++; $display("FAIL rm_grant: got %b expected 0010", arb.req_ready); end
    step();
    arb.req_valid = 4'b0000;
    step();
    reset = 1'b1;
    #1;
    n_checks++;
    if (arb.rsp_valid !== 1'b0 || arb.busy !== 1'b0 || arb.req_ready !== 4'b0 ||
        {arb.alu_a, arb.alu_b, arb.alu_opsel} !== 20'h0 ||
        {arb.rsp_id, arb.rsp_data, arb.rsp_carry, arb.rsp_err} !== 12'h0) begin
      n_fail++;
      $display("FAIL rm_outputs: got v=%b busy=%b a=%h b=%h op=%h id=%0d data=%h expected all 0",
               arb.rsp_valid, arb.busy, arb.alu_a, arb.alu_b, arb.alu_opsel, arb.rsp_id, arb.rsp_data);
    end
    step();
    reset = 1'b0;
    ptr   = N - 1;
    bad   = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (arb.rsp_valid !== 1'b0 || arb.busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) begin n_fail++; $display("FAIL rm_no_rsp: got %0d active cycles expected 0", bad); end
    arb.req_valid = 4'b1111;
    #1;
    n_checks++;
    if (arb.req_ready !== 4'b0001) begin n_fail++; $display("FAIL rm_next_grant: got %b expected 0001", arb.req_ready); end
    arb.req_valid = 4'b0000;
    step();
  endtask

  task automatic test_random();
    int pick, cnt, lat, d, r;
    logic [3:0] mask;
    logic [9:0] e;
    logic [N-1:0] expv;
    for (int t = 0; t < 40; t++) begin
      mask = 4'($urandom_range(1, 15));
      rand_ops(1'b0);
      if ($urandom_range(0, 3) == 0) begin
        r = $urandom_range(0, N - 1);
        op_m[r] = 4'd3;
        b_m[r]  = 8'd0;
        drive_ops();
      end
      pick = -1;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (ptr + k) % N;
        if (pick < 0 && mask[idx]) pick = idx;
      end
      expv = '0; expv[pick] = 1'b1;
      e   = exp_rsp(a_m[pick], b_m[pick], op_m[pick]);
      lat = exp_lat(b_m[pick], op_m[pick]);
      arb.req_valid = mask;
      #1;
      n_checks++;
      if (arb.req_ready !== expv) begin
        n_fail++; $display("FAIL rnd_grant%0d: got %b expected %b (mask %b)", t, arb.req_ready, expv, mask);
      end
      step();
      arb.req_valid = 4'b0000;
      cnt = 1;
      while (!arb.rsp_valid && cnt < 12) begin step(); cnt++; end
      n_checks++;
      if (cnt !== lat || arb.rsp_id !== IW'(pick) || arb.rsp_data !== e[7:0] || arb.rsp_carry !== e[8] || arb.rsp_err !== e[9]) begin
        n_fail++;
        $display("FAIL rnd_rsp%0d: got lat=%0d id=%0d data=%h c=%b e=%b expected %0d/%0d/%h/%b/%b",
                 t, cnt, arb.rsp_id, arb.rsp_data, arb.rsp_carry, arb.rsp_err, lat, pick, e[7:0], e[8], e[9]);
      end
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        arb.req_valid = 4'($urandom);
        #1;
        n_checks++;
        if (arb.req_ready !== 4'b0 || arb.rsp_valid !== 1'b1 || arb.rsp_data !== e[7:0]) begin
          n_fail++;
          $display("FAIL rnd_hold%0d: got ready=%b v=%b data=%h expected 0000/1/%h", t, arb.req_ready, arb.rsp_valid, arb.rsp_data, e[7:0]);
        end
        step();
      end
      arb.rsp_ready = 1'b1;
      step();
      arb.rsp_ready = 1'b0;
      arb.req_valid = 4'b0000;
      ptr = pick;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    arb.req_valid = '0;
    arb.req_a     = '0;
    arb.req_b     = '0;
    arb.req_op    = '0;
    arb.rsp_ready = 1'b0;
    test_reset();
    test_single_add();
    test_round_robin();
    test_backpressure();
    test_illegal_op();
    test_div_zero();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
